// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
// lsu_ctrl: load/store initiator for the data RAM. Accepts one request at a
// time, issues a single aligned RAM access or a sequence of byte accesses for
// misaligned halfwords/words, and returns the extended load data or an error
// as a one-cycle response pulse. All outputs are registered.
module lsu_ctrl #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [2:0]  req_access,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_load,
   output logic        mem_store,
   output logic [2:0]  mem_access,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t      state;
   logic [2:0]  acc_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [31:0] asm_r;
   logic        load_r;
   logic [1:0]  idx;
   logic [1:0]  last_idx;

   logic        access_ok;
   logic        misaligned;
   logic        req_bad;
   logic [1:0]  idx_next;
   logic [31:0] asm_next;

   // Sign- or zero-extend a right-justified load value according to its access size.
   function automatic logic [31:0] extend_load(input logic [2:0] acc, input logic [31:0] d);
      logic [31:0] r;
      case (acc)
         3'b000:  r = {{24{d[7]}}, d[7:0]};
         3'b001:  r = {{16{d[15]}}, d[15:0]};
         3'b100:  r = {24'b0, d[7:0]};
         3'b101:  r = {16'b0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Classify the incoming request: legal encoding, alignment, and whether it must be rejected.
   always_comb begin
      access_ok = 1'b0;
      case (req_access)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: access_ok = 1'b1;
         default:                                access_ok = 1'b0;
      endcase
      misaligned = ((req_access[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_access[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      req_bad = (req_load == req_store) || !access_ok ||
                (req_store && req_access[2]) ||
                (!ALLOW_MISALIGNED && misaligned);
   end

   // Next byte index and the assembly word with the byte returned this cycle merged in.
   always_comb begin
      idx_next = idx + 2'd1;
      asm_next = asm_r;
      asm_next[{idx, 3'b000} +: 8] = mem_rdata[7:0];
   end

   // Request sequencer: accept, single access or byte split, then one response cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'b0;
         mem_load   <= 1'b0;
         mem_store  <= 1'b0;
         mem_access <= 3'b0;
         mem_addr   <= 32'b0;
         mem_wdata  <= 32'b0;
         acc_r      <= 3'b0;
         addr_r     <= 32'b0;
         wdata_r    <= 32'b0;
         asm_r      <= 32'b0;
         load_r     <= 1'b0;
         idx        <= 2'd0;
         last_idx   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  acc_r     <= req_access;
                  addr_r    <= req_addr;
                  wdata_r   <= req_wdata;
                  load_r    <= req_load;
                  idx       <= 2'd0;
                  asm_r     <= 32'b0;
                  last_idx  <= req_access[1] ? 2'd3 : 2'd1;
                  if (req_bad) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'b0;
                  end else if (misaligned) begin
                     state      <= SPLIT;
                     mem_load   <= req_load;
                     mem_store  <= req_store;
                     mem_access <= req_load ? 3'b100 : 3'b000;
                     mem_addr   <= req_addr;
                     mem_wdata  <= {24'b0, req_wdata[7:0]};
                  end else begin
                     state      <= ACCESS;
                     mem_load   <= req_load;
                     mem_store  <= req_store;
                     mem_access <= req_access;
                     mem_addr   <= req_addr;
                     mem_wdata  <= req_wdata;
                  end
               end
            end
            ACCESS: begin
               state      <= RESP;
               mem_load   <= 1'b0;
               mem_store  <= 1'b0;
               mem_access <= 3'b0;
               mem_addr   <= 32'b0;
               mem_wdata  <= 32'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= load_r ? extend_load(acc_r, mem_rdata) : 32'b0;
            end
            SPLIT: begin
               if (idx == last_idx) begin
                  state      <= RESP;
                  mem_load   <= 1'b0;
                  mem_store  <= 1'b0;
                  mem_access <= 3'b0;
                  mem_addr   <= 32'b0;
                  mem_wdata  <= 32'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_r ? extend_load(acc_r, asm_next) : 32'b0;
               end else begin
                  idx       <= idx_next;
                  asm_r     <= asm_next;
                  mem_addr  <= addr_r + {30'b0, idx_next};
                  mem_wdata <= {24'b0, wdata_r[{idx_next, 3'b000} +: 8]};
               end
            end
            RESP: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'b0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
// tb_lsu_ctrl: randomized and directed requests against a byte-array RAM.
// Expected responses come from a byte-level reference model and are queued at
// issue time; a monitor pops them whenever the design presents a response.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_load, req_store;
   logic [2:0]  req_access;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_load, mem_store;
   logic [2:0]  mem_access;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        s_req_valid, s_req_ready, s_req_load, s_req_store;
   logic [2:0]  s_req_access;
   logic [31:0] s_req_addr, s_req_wdata;
   logic        s_resp_valid, s_resp_err;
   logic [31:0] s_resp_rdata;
   logic        s_mem_load, s_mem_store;
   logic [2:0]  s_mem_access;
   logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;

   lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
      .req_access(req_access), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_load(mem_load), .mem_store(mem_store), .mem_access(mem_access),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
      .clk(clk), .rst(rst),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_load(s_req_load), .req_store(s_req_store),
      .req_access(s_req_access), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
      .resp_valid(s_resp_valid), .resp_err(s_resp_err), .resp_rdata(s_resp_rdata),
      .mem_load(s_mem_load), .mem_store(s_mem_store), .mem_access(s_mem_access),
      .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
   );

   assign s_mem_rdata = s_mem_load ? 32'hCAFEF00D : 32'h0;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: combinational raw little-endian read, byte-lane write on posedge, backdoor port
   logic [7:0] ram [0:1023];
   logic       ram_clr, bd_we;
   logic [9:0] bd_addr;
   logic [7:0] bd_data;
   logic [9:0] ra;
   logic [7:0] b0, b1, b2, b3;
   assign ra = mem_addr[9:0];
   assign b0 = ram[ra];
   assign b1 = ram[ra + 10'd1];
   assign b2 = ram[ra + 10'd2];
   assign b3 = ram[ra + 10'd3];

   always_comb begin
      mem_rdata = 32'h0;
      if (mem_load) begin
         case (mem_access)
            3'b000, 3'b100: mem_rdata = {24'h0, b0};
            3'b001, 3'b101: mem_rdata = {16'h0, b1, b0};
            3'b010:         mem_rdata = {b3, b2, b1, b0};
            default:        mem_rdata = 32'h0;
         endcase
      end
   end

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 8'h0;
      end else begin
         if (bd_we) ram[bd_addr] <= bd_data;
         if (mem_store) begin
            ram[ra] <= mem_wdata[7:0];
            if (mem_access[1:0] != 2'b00) ram[ra + 10'd1] <= mem_wdata[15:8];
            if (mem_access[1:0] == 2'b10) begin
               ram[ra + 10'd2] <= mem_wdata[23:16];
               ram[ra + 10'd3] <= mem_wdata[31:24];
            end
         end
      end
   end

   // Reference model state and scoreboard
   logic [7:0] ref_mem [0:1023];

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
      int          n_ld;
      int          n_st;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   ld_cnt = 0;
   int   st_cnt = 0;
   int   s_strobes = 0;
   bit   abort = 0;

   function automatic int size_of(input logic [2:0] acc);
      if (acc == 3'b001 || acc == 3'b101) return 2;
      if (acc == 3'b010) return 4;
      return 1;
   endfunction

   function automatic bit is_misaligned(input logic [2:0] acc, input logic [31:0] addr);
      return (addr % 32'(size_of(acc))) != 32'd0;
   endfunction

   function automatic bit is_bad(input logic ld, input logic st, input logic [2:0] acc,
                                 input logic [31:0] addr, input bit allow);
      bit legal;
      legal = (acc == 3'b000) || (acc == 3'b001) || (acc == 3'b010) ||
              (acc == 3'b100) || (acc == 3'b101);
      if (ld == st) return 1;
      if (!legal) return 1;
      if (st && (acc == 3'b100 || acc == 3'b101)) return 1;
      if (!allow && is_misaligned(acc, addr)) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] acc, input logic [31:0] addr);
      logic [31:0] v;
      logic [31:0] a;
      v = 32'h0;
      for (int i = 0; i < size_of(acc); i++) begin
         a = addr + 32'(i);
         v = v + (32'(ref_mem[a[9:0]]) << (8 * i));
      end
      if (acc == 3'b000 && v >= 32'd128)   v = v - 32'd256;
      if (acc == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] acc, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] a;
      logic [31:0] sh;
      for (int i = 0; i < size_of(acc); i++) begin
         a = addr + 32'(i);
         sh = wdata >> (8 * i);
         ref_mem[a[9:0]] = sh[7:0];
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   task automatic bdWrite(input logic [9:0] a, input logic [7:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we = 1'b1;
      ref_mem[a] = d;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
   endtask

   // Drive one request, wait for acceptance, and queue the model's expected response.
   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] acc,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit track, output bit ok);
      exp_t e;
      int   waited;
      bit   bad, mis;
      int   n;
      req_load = ld;
      req_store = st;
      req_access = acc;
      req_addr = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      ok = 0;
      waited = 0;
      while (!ok && waited < 40) begin
         @(negedge clk);
         if (req_ready) ok = 1;
         else waited++;
      end
      if (!ok) begin
         total++;
         $display("[TB] FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waited);
         req_valid = 1'b0;
         return;
      end
      bad = is_bad(ld, st, acc, addr, 1'b1);
      mis = is_misaligned(acc, addr);
      n = size_of(acc);
      e.err = bad;
      e.rdata = (!bad && ld) ? ref_load(acc, addr) : 32'h0;
      e.cyc = cyc + (bad ? 1 : (mis ? n + 1 : 2));
      e.n_ld = (!bad && ld) ? (mis ? n : 1) : 0;
      e.n_st = (!bad && st) ? (mis ? n : 1) : 0;
      if (!bad && st && track) ref_store(acc, addr, wdata);
      if (track) sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Monitor: count strobe cycles and compare each response against the queue head.
   task automatic runMonitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (s_mem_load || s_mem_store) s_strobes++;
         if (rst) begin
            ld_cnt = 0;
            st_cnt = 0;
         end else begin
            if (mem_load) ld_cnt++;
            if (mem_store) st_cnt++;
            if (resp_valid) begin
               if (sb.size() == 0) begin
                  total++;
                  $display("[TB] FAIL resp_unexpected: resp_valid=1 at cycle %0d, required 0", cyc);
               end else begin
                  e = sb.pop_front();
                  checkOutput("resp_err", 32'(resp_err), 32'(e.err));
                  checkOutput("resp_rdata", resp_rdata, e.rdata);
                  checkOutput("resp_cycle", 32'(cyc), 32'(e.cyc));
                  checkOutput("load_strobes", 32'(ld_cnt), 32'(e.n_ld));
                  checkOutput("store_strobes", 32'(st_cnt), 32'(e.n_st));
               end
               ld_cnt = 0;
               st_cnt = 0;
            end else begin
               checkOutput("idle_rdata", resp_rdata, 32'h0);
               checkOutput("idle_err", 32'(resp_err), 32'h0);
            end
         end
      end
   endtask

   // Strict instance: misaligned requests must be rejected without touching the RAM.
   task automatic strictCase(input logic [2:0] acc, input logic [31:0] addr, inout int exp_strobes);
      int  t, waited;
      bit  bad, seen;
      bad = is_bad(1'b1, 1'b0, acc, addr, 1'b0);
      s_req_load = 1'b1;
      s_req_store = 1'b0;
      s_req_access = acc;
      s_req_addr = addr;
      s_req_wdata = 32'h0;
      s_req_valid = 1'b1;
      seen = 0;
      waited = 0;
      while (!seen && waited < 20) begin
         @(negedge clk);
         if (s_req_ready) seen = 1;
         else waited++;
      end
      t = cyc;
      @(posedge clk);
      #1;
      s_req_valid = 1'b0;
      if (!seen) begin
         total++;
         $display("[TB] FAIL strict_accept_timeout: s_req_ready=0, required 1");
         return;
      end
      seen = 0;
      waited = 0;
      while (!seen && waited < 10) begin
         @(negedge clk);
         if (s_resp_valid) seen = 1;
         else waited++;
      end
      if (!seen) begin
         total++;
         $display("[TB] FAIL strict_resp_timeout: no resp_valid in 10 cycles, required 1");
         return;
      end
      checkOutput("strict_err", 32'(s_resp_err), 32'(bad));
      checkOutput("strict_rdata", s_resp_rdata, bad ? 32'h0 : 32'hCAFEF00D);
      checkOutput("strict_cycle", 32'(cyc - t), bad ? 32'd1 : 32'd2);
      if (!bad) exp_strobes++;
   endtask

   initial begin
      bit          ok;
      logic [2:0]  acc_tab [5];
      logic [2:0]  acc;
      logic        ld, st;
      logic [31:0] addr;
      int          r, w, mism, exp_s;
      acc_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      rst = 1'b1;
      ram_clr = 1'b1;
      bd_we = 1'b0;
      bd_addr = 10'h0;
      bd_data = 8'h0;
      req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_access = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
      s_req_valid = 1'b0; s_req_load = 1'b0; s_req_store = 1'b0;
      s_req_access = 3'b0; s_req_addr = 32'h0; s_req_wdata = 32'h0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      ram_clr = 1'b0;
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_mem_strobes", 32'({mem_load, mem_store}), 32'h0);
      checkOutput("rst_mem_access", 32'(mem_access), 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fork
         runMonitor();
      join_none

      // Directed: aligned word load, misaligned halfword loads, misaligned word store then load
      bdWrite(10'h100, 8'hEF); bdWrite(10'h101, 8'hBE);
      bdWrite(10'h102, 8'hAD); bdWrite(10'h103, 8'hDE);
      applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 1, ok);
      bdWrite(10'h101, 8'h80); bdWrite(10'h102, 8'hFF);
      applyStimulus(1, 0, 3'b001, 32'h101, 32'h0, 1, ok);
      applyStimulus(1, 0, 3'b101, 32'h101, 32'h0, 1, ok);
      applyStimulus(0, 1, 3'b010, 32'h203, 32'h11223344, 1, ok);
      applyStimulus(1, 0, 3'b010, 32'h204, 32'h0, 1, ok);
      // Directed errors: bad encoding, both directions, neither direction, unsigned store
      applyStimulus(1, 0, 3'b011, 32'h100, 32'h0, 1, ok);
      applyStimulus(1, 1, 3'b010, 32'h300, 32'h12345678, 1, ok);
      applyStimulus(0, 0, 3'b000, 32'h300, 32'h12345678, 1, ok);
      applyStimulus(0, 1, 3'b100, 32'h300, 32'h000000AB, 1, ok);
      // Directed wrap past the top of the address space
      applyStimulus(0, 1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 1, ok);
      applyStimulus(1, 0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, ok);

      // Randomized traffic
      for (int k = 0; k < 300 && !abort; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin ld = 1; st = 1; end
         else if (r == 1) begin ld = 0; st = 0; end
         else begin ld = 1'($urandom_range(0, 1)); st = !ld; end
         if ($urandom_range(0, 7) == 0) acc = 3'($urandom_range(0, 7));
         else acc = acc_tab[$urandom_range(0, 4)];
         if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
         else addr = 32'h100 + 32'($urandom_range(0, 63));
         applyStimulus(ld, st, acc, addr, $urandom, 1, ok);
         if (!ok) abort = 1;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      // Reset during the first byte of a split store: only that byte lands
      if (!abort) begin
         applyStimulus(0, 1, 3'b010, 32'h201, 32'h5A6B7C8D, 0, ok);
         if (ok) begin
            rst = 1'b1;
            ref_mem[10'h201] = 8'h8D;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            checkOutput("midrst_req_ready", 32'(req_ready), 32'h1);
            checkOutput("midrst_strobes", 32'({mem_load, mem_store}), 32'h0);
            checkOutput("midrst_resp_valid", 32'(resp_valid), 32'h0);
            repeat (6) @(negedge clk);
         end
      end

      w = 0;
      while (sb.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      checkOutput("sb_drained", 32'(sb.size()), 32'h0);

      mism = 0;
      for (int i = 0; i < 1024; i++) begin
         if (ram[i] !== ref_mem[i]) begin
            if (mism == 0) $display("[TB] first RAM difference at 0x%03h: got 0x%02h, model 0x%02h", i, ram[i], ref_mem[i]);
            mism++;
         end
      end
      checkOutput("ram_image_diffs", 32'(mism), 32'h0);

      exp_s = 0;
      strictCase(3'b010, 32'h102, exp_s);
      strictCase(3'b001, 32'h101, exp_s);
      strictCase(3'b010, 32'h100, exp_s);
      @(negedge clk);
      checkOutput("strict_strobe_cycles", 32'(s_strobes), 32'(exp_s));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
